// File: rtl/reset_sequencer_pkg.sv
// Shared types and default parameters for the staged reset sequencer.
// Imported by reset_sequencer and the bench.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    COUNT,
    DONE
  } rseq_state_e;

  localparam int RSEQ_NUM_OUT     = 2;
  localparam int RSEQ_STAGE_DLY   = 5;
  localparam int RSEQ_SYNC_STAGES = 2;

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer, STAGES flops deep.
// Ports: clk, rst_n (async, active-low) -> srst_n (synchronized).
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic srst_n
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign srst_n = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: NUM_OUT active-low resets freed in index order,
// STAGE_DLY cycles apart, with per-stage hold and software re-reset.
// Ports: clk, rst_n, sw_rst_req_i, hold_i[NUM_OUT] in;
//        rst_n_o[NUM_OUT], busy_o, done_o out (all registered).
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_OUT     = RSEQ_NUM_OUT,
  parameter int STAGE_DLY   = RSEQ_STAGE_DLY,
  parameter int SYNC_STAGES = RSEQ_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req_i,
  input  logic [NUM_OUT-1:0] hold_i,
  output logic [NUM_OUT-1:0] rst_n_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(STAGE_DLY + 1);
  localparam int STG_W = $clog2(NUM_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_OUT - 1);

  if (NUM_OUT < 1) begin : g_chk_num
    $error("NUM_OUT must be >= 1");
  end
  if (STAGE_DLY < 1) begin : g_chk_dly
    $error("STAGE_DLY must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end

  logic srst_n;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .srst_n (srst_n)
  );

  rseq_state_e        state, state_d;
  logic [STG_W-1:0]   stage, stage_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               hold_cur;
  logic               step;

  always_comb begin
    hold_cur = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (stage == STG_W'(k)) hold_cur = hold_i[k];
    end
  end

  always_comb begin
    state_d = state;
    stage_d = stage;
    cnt_d   = cnt;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = done_q;
    step    = 1'b0;
    if (sw_rst_req_i) begin
      state_d = ASSERT;
      stage_d = '0;
      cnt_d   = '0;
      rst_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      unique case (state)
        ASSERT: begin
          rst_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          stage_d = '0;
          cnt_d   = '0;
          // The edge leaving ASSERT is already the
          // first cycle of stage 0's gap.
          if (srst_n) begin
            state_d = COUNT;
            step    = 1'b1;
          end
        end
        COUNT: step = 1'b1;
        DONE: begin
          rst_d  = '1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        default: state_d = ASSERT;
      endcase
      if (step) begin
        if (cnt != CNT_LAST) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (!hold_cur) begin
          for (int k = 0; k < NUM_OUT; k++) begin
            if (stage == STG_W'(k)) rst_d[k] = 1'b1;
          end
          cnt_d   = '0;
          stage_d = stage + STG_W'(1);
          if (stage == STG_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ASSERT;
      stage  <= '0;
      cnt    <= '0;
      rst_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      stage  <= stage_d;
      cnt    <= cnt_d;
      rst_q  <= rst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign rst_n_o = rst_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table plus hand sequences,
// expected values flow through a scoreboard queue.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, sw;
  logic [1:0] hold, ro;
  logic       busy, done;
  logic       rst_n2, sw2;
  logic [3:0] hold2, ro2;
  logic       busy2, done2;

  always #10 clk = ~clk;

  reset_sequencer u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_rst_req_i (sw),
    .hold_i       (hold),
    .rst_n_o      (ro),
    .busy_o       (busy),
    .done_o       (done)
  );

  reset_sequencer #(
    .NUM_OUT     (4),
    .STAGE_DLY   (1),
    .SYNC_STAGES (3)
  ) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n2),
    .sw_rst_req_i (sw2),
    .hold_i       (hold2),
    .rst_n_o      (ro2),
    .busy_o       (busy2),
    .done_o       (done2)
  );

  typedef struct {
    logic       rst;
    logic       sw;
    logic [1:0] hold;
    logic [1:0] ro;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] expq[$];
  int         tests = 0;
  int         fails = 0;

  function automatic void add(input logic r, input logic s,
                              input logic [1:0] h, input logic [1:0] o,
                              input logic b, input logic d, input int n);
    vec_t v;
    v.rst = r; v.sw = s; v.hold = h;
    v.ro = o; v.busy = b; v.done = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic logic [5:0] obs1();
    return {busy, done, 2'b00, ro};
  endfunction

  function automatic logic [5:0] obs2();
    return {busy2, done2, ro2};
  endfunction

  function automatic logic [5:0] exp4(input int n);
    logic [3:0] t;
    t = 4'((1 << n) - 1);
    return {(n < 4), (n >= 4), t};
  endfunction

  task automatic check(input string nm, input logic [5:0] act);
    logic [5:0] e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL %s: got %b, scoreboard empty", nm, act);
    end else begin
      e = expq.pop_front();
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %b (busy,done,rst) want %b", nm, act, e);
      end
    end
  endtask

  task automatic cyc1(input logic s, input logic [1:0] h,
                      input logic [5:0] e, input string nm);
    sw = s; hold = h;
    expq.push_back(e);
    @(negedge clk);
    check(nm, obs1());
  endtask

  task automatic cyc4(input logic s, input logic [3:0] h,
                      input int n, input string nm);
    sw2 = s; hold2 = h;
    expq.push_back(exp4(n));
    @(negedge clk);
    check(nm, obs2());
  endtask

  initial begin
    rst_n = 1'b1; sw = 1'b0; hold = 2'b00;
    rst_n2 = 1'b1; sw2 = 1'b0; hold2 = 4'b0000;
    #1;
    rst_n = 1'b0; rst_n2 = 1'b0;

    // power-on: T0 = edge 2, bit0 at edge 7, bit1 + done at edge 12
    add(0, 0, 2'b00, 2'b00, 1, 0, 3);
    add(1, 0, 2'b00, 2'b00, 1, 0, 6);
    add(1, 0, 2'b00, 2'b01, 1, 0, 5);
    add(1, 0, 2'b00, 2'b11, 0, 1, 3);
    // software re-reset from DONE
    add(1, 1, 2'b00, 2'b00, 1, 0, 1);
    add(1, 0, 2'b00, 2'b00, 1, 0, 4);
    add(1, 0, 2'b00, 2'b01, 1, 0, 5);
    add(1, 0, 2'b00, 2'b11, 0, 1, 2);
    // restart while output is 01
    add(1, 1, 2'b00, 2'b00, 1, 0, 1);
    add(1, 0, 2'b00, 2'b00, 1, 0, 4);
    add(1, 0, 2'b00, 2'b01, 1, 0, 2);
    add(1, 1, 2'b00, 2'b00, 1, 0, 1);
    add(1, 0, 2'b00, 2'b00, 1, 0, 4);
    add(1, 0, 2'b00, 2'b01, 1, 0, 5);
    add(1, 0, 2'b00, 2'b11, 0, 1, 2);
    // hold on stage 1: three extra cycles
    add(1, 1, 2'b10, 2'b00, 1, 0, 1);
    add(1, 0, 2'b10, 2'b00, 1, 0, 4);
    add(1, 0, 2'b10, 2'b01, 1, 0, 5);
    add(1, 0, 2'b10, 2'b01, 1, 0, 3);
    add(1, 0, 2'b00, 2'b11, 0, 1, 1);
    add(1, 0, 2'b11, 2'b11, 0, 1, 2);
    // hold on stage 0; stale hold[0] ignored during stage 1
    add(1, 1, 2'b01, 2'b00, 1, 0, 1);
    add(1, 0, 2'b01, 2'b00, 1, 0, 6);
    add(1, 0, 2'b00, 2'b01, 1, 0, 1);
    add(1, 0, 2'b01, 2'b01, 1, 0, 4);
    add(1, 0, 2'b01, 2'b11, 0, 1, 1);
    add(1, 0, 2'b00, 2'b11, 0, 1, 1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst;
      sw    = vecs[i].sw;
      hold  = vecs[i].hold;
      expq.push_back({vecs[i].busy, vecs[i].done, 2'b00, vecs[i].ro});
      @(negedge clk);
      check($sformatf("vec%0d", i), obs1());
    end

    // async reset mid-sequence, then a full power-on sequence
    cyc1(1'b1, 2'b00, 6'b10_0000, "async_pre_sw");
    for (int e = 1; e <= 6; e++) begin
      cyc1(1'b0, 2'b00, (e >= 5) ? 6'b10_0001 : 6'b10_0000,
           $sformatf("async_pre%0d", e));
    end
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    expq.push_back(6'b10_0000);
    check("async_drop", obs1());
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      cyc1(1'b0, 2'b00,
           (e >= 12) ? 6'b01_0011 :
           (e >= 7)  ? 6'b10_0001 : 6'b10_0000,
           $sformatf("async_post%0d", e));
    end

    // NUM_OUT=4, STAGE_DLY=1, SYNC_STAGES=3: T0 = edge 3
    expq.push_back(exp4(0));
    check("p4_reset", obs2());
    rst_n2 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc4(1'b0, 4'b0000, (e <= 3) ? 0 : ((e - 3 > 4) ? 4 : e - 3),
           $sformatf("p4_edge%0d", e));
    end
    cyc4(1'b1, 4'b0100, 0, "p4_sw");
    cyc4(1'b0, 4'b0100, 1, "p4_s1");
    cyc4(1'b0, 4'b0100, 2, "p4_s2");
    cyc4(1'b0, 4'b0100, 2, "p4_hold");
    cyc4(1'b0, 4'b0000, 3, "p4_s3");
    cyc4(1'b0, 4'b0000, 4, "p4_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
